// File: rtl/memory_access_stage.sv
// -----------------------------------------------------------------------------
// memory_access_stage
//
// MEM stage of the pipeline: a 2^ADDR_WIDTH-word data memory followed by the
// MEM/WB pipeline register. All state updates on the falling edge of clk.
// Each access takes WAIT_STATES+1 cycles. The stage raises stall for the first
// WAIT_STATES of them and inserts a write-back bubble on each of those cycles.
//
// Optional feature macro: SUBWORD_ACCESS_EN
//   When defined, resultIn is a byte address. The stage then supports byte,
//   half and word loads/stores, and loads can be sign- or zero-extended.
//   This mode requires DATA_WIDTH = 32.
//   When undefined, accessSize and loadUnsigned are ignored and all accesses
//   are whole words.
//
// Ports:
//   clk                 in   pipeline clock, state changes on negedge
//   resetN              in   asynchronous active-low reset
//   writeBackControlIn  in   [WB_WIDTH]   write-back control from execute
//   memAccessControl    in   [2]          bit1 memRead, bit0 memWrite
//   accessSize          in   [2]          00 byte, 01 half, 10/11 word
//   loadUnsigned        in   1            zero-extend sub-word loads
//   resultIn            in   [DATA_WIDTH] ALU result / memory address
//   writeData           in   [DATA_WIDTH] store data
//   rdIn                in   [RD_WIDTH]   destination register
//   stall               out  1            combinational hold request upstream
//   writeBackControlOut out  [WB_WIDTH]   registered
//   readData            out  [DATA_WIDTH] registered load data
//   resultOut           out  [DATA_WIDTH] registered pass-through of resultIn
//   rdOut               out  [RD_WIDTH]   registered pass-through of rdIn
// -----------------------------------------------------------------------------
module memory_access_stage #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int WB_WIDTH    = 2,
  parameter int RD_WIDTH    = 5,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [WB_WIDTH-1:0]   writeBackControlIn,
  input  logic [1:0]            memAccessControl,
  input  logic [1:0]            accessSize,
  input  logic                  loadUnsigned,
  input  logic [DATA_WIDTH-1:0] resultIn,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [RD_WIDTH-1:0]   rdIn,
  output logic                  stall,
  output logic [WB_WIDTH-1:0]   writeBackControlOut,
  output logic [DATA_WIDTH-1:0] readData,
  output logic [DATA_WIDTH-1:0] resultOut,
  output logic [RD_WIDTH-1:0]   rdOut
);

  localparam int DEPTH    = 2 ** ADDR_WIDTH;
  localparam bit HAS_WAIT = (WAIT_STATES > 0);
  localparam int CNT_W    = HAS_WAIT ? $clog2(WAIT_STATES + 1) : 1;
  localparam int CNT_INIT = HAS_WAIT ? WAIT_STATES - 1 : 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;

  // Storage holds (contents XOR word index). At power-up the array is
  // all zeros, so word i then reads back as i, with no load sequence.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_mem_read;
  logic                  w_mem_write;
  logic                  w_access;
  logic                  w_stall;
  logic                  w_complete;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_index;
  logic [DATA_WIDTH-1:0] w_word;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_store_word;

  // Scrambling key applied to a word: its zero-extended index.
  function automatic logic [DATA_WIDTH-1:0] index_key(input logic [ADDR_WIDTH-1:0] idx);
    return DATA_WIDTH'(idx);
  endfunction

`ifdef SUBWORD_ACCESS_EN
  logic [1:0] w_lane;

  // Select the addressed lane and extend it to a full word.
  function automatic logic [DATA_WIDTH-1:0] load_extract(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            lane,
    input logic [1:0]            size,
    input logic                  uns
  );
    logic [DATA_WIDTH-1:0] v_byte_sh;
    logic [DATA_WIDTH-1:0] v_half_sh;
    logic [DATA_WIDTH-1:0] v_res;
    v_byte_sh = word >> {lane, 3'b000};
    v_half_sh = word >> {lane[1], 4'b0000};
    case (size)
      2'b00: begin
        if (uns) begin
          v_res = {{(DATA_WIDTH-8){1'b0}}, v_byte_sh[7:0]};
        end else begin
          v_res = {{(DATA_WIDTH-8){v_byte_sh[7]}}, v_byte_sh[7:0]};
        end
      end
      2'b01: begin
        if (uns) begin
          v_res = {{(DATA_WIDTH-16){1'b0}}, v_half_sh[15:0]};
        end else begin
          v_res = {{(DATA_WIDTH-16){v_half_sh[15]}}, v_half_sh[15:0]};
        end
      end
      default: v_res = word;
    endcase
    return v_res;
  endfunction

  // Merge store data into the old word.
  // Half stores align down to an even lane.
  function automatic logic [DATA_WIDTH-1:0] store_merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [1:0]            lane,
    input logic [1:0]            size
  );
    logic [DATA_WIDTH-1:0] v_mask;
    logic [DATA_WIDTH-1:0] v_data;
    case (size)
      2'b00: begin
        v_mask = {{(DATA_WIDTH-8){1'b0}}, 8'hFF} << {lane, 3'b000};
        v_data = {(DATA_WIDTH/8){wdata[7:0]}};
      end
      2'b01: begin
        v_mask = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF} << {lane[1], 4'b0000};
        v_data = {(DATA_WIDTH/16){wdata[15:0]}};
      end
      default: begin
        v_mask = {DATA_WIDTH{1'b1}};
        v_data = wdata;
      end
    endcase
    return (old_word & ~v_mask) | (v_data & v_mask);
  endfunction

  assign w_index      = resultIn[ADDR_WIDTH+1:2];
  assign w_lane       = resultIn[1:0];
  assign w_load       = load_extract(w_word, w_lane, accessSize, loadUnsigned);
  assign w_store_word = store_merge(w_word, writeData, w_lane, accessSize);
`else
  logic w_unused;

  assign w_index      = resultIn[ADDR_WIDTH-1:0];
  assign w_load       = w_word;
  assign w_store_word = writeData;
  assign w_unused     = ^{accessSize, loadUnsigned};
`endif

  assign w_mem_read  = memAccessControl[1];
  assign w_mem_write = memAccessControl[0];
  assign w_access    = w_mem_read | w_mem_write;
  assign w_word      = r_mem[w_index] ^ index_key(w_index);
  assign w_mem_we    = w_complete & w_mem_write;
  assign stall       = w_stall;

  // Stall request and the access-completes-this-edge decision.
  // Both are forced low while reset is held.
  always_comb begin
    w_stall    = 1'b0;
    w_complete = 1'b0;
    if (!resetN) begin
      w_stall    = 1'b0;
      w_complete = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            if (HAS_WAIT) begin
              w_stall = 1'b1;
            end else begin
              w_complete = 1'b1;
            end
          end else begin
            w_complete = 1'b0;
          end
        end
        S_WAIT: begin
          if (r_cnt != {CNT_W{1'b0}}) begin
            w_stall = 1'b1;
          end else begin
            w_complete = 1'b1;
          end
        end
        default: begin
          w_stall    = 1'b0;
          w_complete = 1'b0;
        end
      endcase
    end
  end

  // Latency FSM and MEM/WB pipeline register.
  // While stalled only the write-back control changes: it is forced to 0
  // (a bubble).
  always_ff @(negedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state             <= S_IDLE;
      r_cnt               <= {CNT_W{1'b0}};
      writeBackControlOut <= {WB_WIDTH{1'b0}};
      readData            <= {DATA_WIDTH{1'b0}};
      resultOut           <= {DATA_WIDTH{1'b0}};
      rdOut               <= {RD_WIDTH{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_stall) begin
            r_state             <= S_WAIT;
            r_cnt               <= CNT_W'(CNT_INIT);
            writeBackControlOut <= {WB_WIDTH{1'b0}};
          end else begin
            writeBackControlOut <= writeBackControlIn;
            resultOut           <= resultIn;
            rdOut               <= rdIn;
            readData            <= w_mem_read ? w_load : {DATA_WIDTH{1'b0}};
          end
        end
        S_WAIT: begin
          if (w_stall) begin
            r_cnt               <= r_cnt - CNT_W'(1'b1);
            writeBackControlOut <= {WB_WIDTH{1'b0}};
          end else begin
            r_state             <= S_IDLE;
            writeBackControlOut <= writeBackControlIn;
            resultOut           <= resultIn;
            rdOut               <= rdIn;
            readData            <= w_mem_read ? w_load : {DATA_WIDTH{1'b0}};
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Data memory write port.
  // It is only enabled on the completing edge, so each access writes once.
  always_ff @(negedge clk) begin
    if (w_mem_we) begin
      r_mem[w_index] <= w_store_word ^ index_key(w_index);
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_access_stage
//
// The bench drives three instances with WAIT_STATES = 0, 2 and 3, each with
// its own inputs and reset. A word-level memory model (one array per
// instance, word i preloaded with i) gives the expected load data.
// Each access records:
//   - the number of stall cycles, which must equal the instance latency,
//   - the bubble seen on the write-back control during those cycles,
//   - the registered outputs after completion.
// -----------------------------------------------------------------------------
module tb_memory_access_stage;

  logic        clk;
  logic        rst_n  [3];
  logic [1:0]  wb_in  [3];
  logic [1:0]  mac    [3];
  logic [1:0]  sz     [3];
  logic        un     [3];
  logic [31:0] res_in [3];
  logic [31:0] wd     [3];
  logic [4:0]  rd_in  [3];
  logic        stall_o[3];
  logic [1:0]  wb_o   [3];
  logic [31:0] rdata_o[3];
  logic [31:0] res_o  [3];
  logic [4:0]  rd_o   [3];

  logic [31:0] mem_m [3][32];
  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    memory_access_stage #(.WAIT_STATES(g == 0 ? 0 : g + 1)) u_dut (
      .clk                (clk),
      .resetN             (rst_n[g]),
      .writeBackControlIn (wb_in[g]),
      .memAccessControl   (mac[g]),
      .accessSize         (sz[g]),
      .loadUnsigned       (un[g]),
      .resultIn           (res_in[g]),
      .writeData          (wd[g]),
      .rdIn               (rd_in[g]),
      .stall              (stall_o[g]),
      .writeBackControlOut(wb_o[g]),
      .readData           (rdata_o[g]),
      .resultOut          (res_o[g]),
      .rdOut              (rd_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic int ws(input int k);
    return (k == 0) ? 0 : k + 1;
  endfunction

  function automatic int model_index(input logic [31:0] addr);
`ifdef SUBWORD_ACCESS_EN
    return int'(addr[6:2]);
`else
    return int'(addr[4:0]);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete access. Stores through this task are whole-word stores.
  task automatic access(input int k, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] wb, input logic [4:0] rdi,
                        input logic [1:0] size, input logic uns,
                        input logic use_exp, input logic [31:0] exp_given);
    logic [31:0] exp_rd;
    int idx;
    int n;
    idx    = model_index(addr);
    exp_rd = rd ? mem_m[k][idx] : 32'h0;
    if (use_exp) exp_rd = exp_given;
    if (wr) mem_m[k][idx] = wdata;
    mac[k] = {rd, wr}; res_in[k] = addr; wd[k] = wdata;
    wb_in[k] = wb; rd_in[k] = rdi; sz[k] = size; un[k] = uns;
    #1;
    n = 0;
    while (stall_o[k] === 1'b1 && n < 12) begin
      @(negedge clk); #1;
      n++;
      check("bubble_wb", 32'(wb_o[k]), 32'h0);
    end
    check("stall_cycles", n, (rd | wr) ? ws(k) : 0);
    @(negedge clk); #1;
    check("readData", rdata_o[k], exp_rd);
    check("resultOut", res_o[k], addr);
    check("rdOut", 32'(rd_o[k]), 32'(rdi));
    check("wbOut", 32'(wb_o[k]), 32'(wb));
    mac[k] = 2'b00;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 32; i++) mem_m[k][i] = 32'(i);
      rst_n[k] = 1'b0; mac[k] = 2'b00; wb_in[k] = 2'b00; sz[k] = 2'b10;
      un[k] = 1'b0; res_in[k] = 32'h0; wd[k] = 32'h0; rd_in[k] = 5'd0;
    end
    #2;
    for (int k = 0; k < 3; k++) begin
      check("reset_readData", rdata_o[k], 32'h0);
      check("reset_resultOut", res_o[k], 32'h0);
      check("reset_wbOut", 32'(wb_o[k]), 32'h0);
      check("reset_stall", 32'(stall_o[k]), 32'h0);
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    #1;

    // Zero wait states: read 20, write then read 5, wrap from 37,
    // then read and write together at 7.
    access(0, 1'b1, 1'b0, 32'd20, 32'h0, 2'b01, 5'd3, 2'b10, 1'b0, 1'b0, 32'h0);
    access(0, 1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 2'b10, 5'd4, 2'b10, 1'b0, 1'b0, 32'h0);
    access(0, 1'b1, 1'b0, 32'd5, 32'h0, 2'b11, 5'd5, 2'b10, 1'b0, 1'b0, 32'h0);
    access(0, 1'b1, 1'b0, 32'd37, 32'h0, 2'b11, 5'd6, 2'b10, 1'b0, 1'b0, 32'h0);
    access(0, 1'b1, 1'b1, 32'd7, 32'h55, 2'b01, 5'd7, 2'b10, 1'b0, 1'b0, 32'h0);
    access(0, 1'b1, 1'b0, 32'd7, 32'h0, 2'b01, 5'd8, 2'b10, 1'b0, 1'b0, 32'h0);

    // Asserting reset clears the registered outputs at once.
    rst_n[0] = 1'b0;
    #1;
    check("async_rst_readData", rdata_o[0], 32'h0);
    check("async_rst_resultOut", res_o[0], 32'h0);
    check("async_rst_rdOut", 32'(rd_o[0]), 32'h0);
    check("async_rst_wbOut", 32'(wb_o[0]), 32'h0);
    @(posedge clk);
    rst_n[0] = 1'b1;
    #1;

    // Two wait states: read 22 after an idle cycle with nonzero write-back control.
    access(1, 1'b0, 1'b0, 32'd1, 32'h0, 2'b11, 5'd2, 2'b10, 1'b0, 1'b0, 32'h0);
    access(1, 1'b1, 1'b0, 32'd22, 32'h0, 2'b10, 5'd17, 2'b10, 1'b0, 1'b0, 32'h0);

    // Three wait states: a write to 9 is aborted by reset after one stall cycle.
    access(2, 1'b0, 1'b0, 32'd2, 32'h0, 2'b11, 5'd1, 2'b10, 1'b0, 1'b0, 32'h0);
    mac[2] = 2'b01; res_in[2] = 32'd9; wd[2] = 32'hAA; wb_in[2] = 2'b11;
    #1;
    check("abort_stall_start", 32'(stall_o[2]), 32'h1);
    @(negedge clk); #1;
    check("abort_bubble", 32'(wb_o[2]), 32'h0);
    check("abort_stall_mid", 32'(stall_o[2]), 32'h1);
    rst_n[2] = 1'b0;
    #1;
    check("abort_stall", 32'(stall_o[2]), 32'h0);
    check("abort_readData", rdata_o[2], 32'h0);
    check("abort_resultOut", res_o[2], 32'h0);
    check("abort_rdOut", 32'(rd_o[2]), 32'h0);
    mac[2] = 2'b00;
    @(negedge clk); #1;
    rst_n[2] = 1'b1;
    #1;
    access(2, 1'b1, 1'b0, 32'd9, 32'h0, 2'b01, 5'd9, 2'b10, 1'b0, 1'b0, 32'h0);

    // Random word accesses on every instance.
    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < 3; k++) begin
        logic r;
        logic w;
        r = 1'($urandom_range(0, 1));
        w = 1'($urandom_range(0, 1));
        access(k, r, w, $urandom, $urandom, 2'($urandom), 5'($urandom),
               2'b10, 1'b0, 1'b0, 32'h0);
      end
    end

`ifdef SUBWORD_ACCESS_EN
    // Sub-word loads from a stored word.
    access(0, 1'b0, 1'b1, 32'h10, 32'h80FF1234, 2'b01, 5'd1, 2'b10, 1'b0, 1'b0, 32'h0);
    access(0, 1'b1, 1'b0, 32'h13, 32'h0, 2'b01, 5'd2, 2'b00, 1'b0, 1'b1, 32'hFFFFFF80);
    access(0, 1'b1, 1'b0, 32'h13, 32'h0, 2'b01, 5'd3, 2'b00, 1'b1, 1'b1, 32'h00000080);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b01, 5'd4, 2'b01, 1'b0, 1'b1, 32'h00001234);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
